// File: rtl/qe_encoder_generator.sv
// Synthetic quadrature encoder source: emits A/B/index at a programmed
// step rate and direction and tracks the signed number of steps emitted.
// Handshake: none; gen_enable/phase_period/direction are level controls
// sampled every clock, with period/direction only acting at the step state.
module qe_encoder_generator #(
   parameter int COUNT_WIDTH    = 16,
   parameter int POS_WIDTH      = 32,
   parameter int PULSES_PER_REV = 512
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   gen_enable,
   input  logic                   direction,
   input  logic [COUNT_WIDTH-1:0] phase_period,
   input  logic                   clear_position,
   output logic                   QE_A,
   output logic                   QE_B,
   output logic                   QE_I,
   output logic [POS_WIDTH-1:0]   gen_position,
   output logic                   running,
   output logic [1:0]             gen_state
);

   localparam int STEPS = 4 * PULSES_PER_REV;
   localparam int REV_W = $clog2(STEPS);
   localparam logic [REV_W-1:0] REV_LAST = REV_W'(STEPS - 1);

   localparam logic [1:0] S_GEN0 = 2'd0;
   localparam logic [1:0] S_GEN1 = 2'd1;
   localparam logic [1:0] S_GEN2 = 2'd2;

   logic [1:0]             state, state_nx;
   logic [COUNT_WIDTH-1:0] timer, timer_nx;
   logic [REV_W-1:0]       rev, rev_step, rev_from_ab, rev_new;
   logic [COUNT_WIDTH-1:0] neff, reload;
   logic [1:0]             ab_step, ab_new;
   logic [POS_WIDTH-1:0]   pos_new;
   logic                   do_step, stop_req;

   assign gen_state = state;

   // Step datapath: next A/B code, step-in-rev and position for this clock
   always_comb begin
      neff     = (phase_period == COUNT_WIDTH'(1)) ? COUNT_WIDTH'(2) : phase_period;
      reload   = neff - COUNT_WIDTH'(2);
      do_step  = (state == S_GEN2);
      stop_req = !gen_enable || (phase_period == '0);

      ab_step = 2'b00;
      if (direction) begin
         case ({QE_A, QE_B})
            2'b00:   ab_step = 2'b10;
            2'b10:   ab_step = 2'b11;
            2'b11:   ab_step = 2'b01;
            default: ab_step = 2'b00;
         endcase
      end else begin
         case ({QE_A, QE_B})
            2'b00:   ab_step = 2'b01;
            2'b01:   ab_step = 2'b11;
            2'b11:   ab_step = 2'b10;
            default: ab_step = 2'b00;
         endcase
      end
      ab_new = do_step ? ab_step : {QE_A, QE_B};

      if (direction) rev_step = (rev == REV_LAST) ? '0 : rev + REV_W'(1);
      else           rev_step = (rev == '0) ? REV_LAST : rev - REV_W'(1);

      // Clear re-aligns the revolution phase to the A/B code being emitted,
      // so the index keeps coinciding with AB=00.
      case (ab_new)
         2'b00:   rev_from_ab = REV_W'(0);
         2'b10:   rev_from_ab = REV_W'(1);
         2'b11:   rev_from_ab = REV_W'(2);
         default: rev_from_ab = REV_W'(3);
      endcase

      if (clear_position) rev_new = rev_from_ab;
      else if (do_step)   rev_new = rev_step;
      else                rev_new = rev;

      if (clear_position) pos_new = '0;
      else if (do_step)   pos_new = direction ? gen_position + POS_WIDTH'(1)
                                              : gen_position - POS_WIDTH'(1);
      else                pos_new = gen_position;
   end

   // Sequencer: idle / count down one quadrature state / emit the step
   always_comb begin
      state_nx = state;
      timer_nx = timer;
      case (state)
         S_GEN0: begin
            timer_nx = '0;
            if (!stop_req) begin
               state_nx = S_GEN1;
               timer_nx = reload;
            end
         end
         S_GEN1: begin
            if (stop_req) begin
               state_nx = S_GEN0;
               timer_nx = '0;
            end else if (timer != '0) begin
               timer_nx = timer - COUNT_WIDTH'(1);
            end else begin
               state_nx = S_GEN2;
            end
         end
         S_GEN2: begin
            // The step itself always completes; only the follow-on is gated.
            if (stop_req) begin
               state_nx = S_GEN0;
               timer_nx = '0;
            end else begin
               state_nx = S_GEN1;
               timer_nx = reload;
            end
         end
         default: begin
            state_nx = S_GEN0;
            timer_nx = '0;
         end
      endcase
   end

   // Registered state and outputs, all cleared asynchronously by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_GEN0;
         timer        <= '0;
         rev          <= '0;
         QE_A         <= 1'b0;
         QE_B         <= 1'b0;
         QE_I         <= 1'b0;
         gen_position <= '0;
         running      <= 1'b0;
      end else begin
         state        <= state_nx;
         timer        <= timer_nx;
         rev          <= rev_new;
         {QE_A, QE_B} <= ab_new;
         gen_position <= pos_new;
         running      <= (state_nx != S_GEN0);
         if (clear_position || do_step) QE_I <= (rev_new == '0);
      end
   end

endmodule

// File: tb/tb_qe_encoder_generator.sv
// Directed bench for qe_encoder_generator (built with 4 pulses per rev).
module tb_qe_encoder_generator;

   logic        clk = 1'b0;
   logic        reset;
   logic        gen_enable;
   logic        direction;
   logic [15:0] phase_period;
   logic        clear_position;
   logic        QE_A, QE_B, QE_I;
   logic [31:0] gen_position;
   logic        running;
   logic [1:0]  gen_state;

   int n_cmp = 0;
   int n_err = 0;

   logic        a_h [0:127];
   logic        b_h [0:127];
   logic        i_h [0:127];
   logic        r_h [0:127];
   logic [31:0] p_h [0:127];

   qe_encoder_generator #(
      .COUNT_WIDTH(16), .POS_WIDTH(32), .PULSES_PER_REV(4)
   ) dut (
      .clk(clk), .reset(reset), .gen_enable(gen_enable), .direction(direction),
      .phase_period(phase_period), .clear_position(clear_position),
      .QE_A(QE_A), .QE_B(QE_B), .QE_I(QE_I), .gen_position(gen_position),
      .running(running), .gen_state(gen_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic apply_reset();
      reset = 1'b0; gen_enable = 1'b0; direction = 1'b1;
      phase_period = 16'd0; clear_position = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   // Entry k holds outputs after the k-th rising edge following the call.
   task automatic capture(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         a_h[k] = QE_A; b_h[k] = QE_B; i_h[k] = QE_I;
         r_h[k] = running; p_h[k] = gen_position;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; gen_enable = 1'b0; direction = 1'b1;
      phase_period = 16'd0; clear_position = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({QE_A, QE_B, QE_I, running} !== 4'b0000) begin
         n_err++; $display("FAIL reset_outs: got %b expected 0000", {QE_A, QE_B, QE_I, running});
      end
      n_cmp++;
      if (gen_position !== 32'd0) begin
         n_err++; $display("FAIL reset_pos: got %0h expected 0", gen_position);
      end
   endtask

   task automatic test_forward();
      apply_reset();
      gen_enable = 1'b1; direction = 1'b1; phase_period = 16'd4;
      capture(36);
      n_cmp++;
      if (r_h[0] !== 1'b1) begin n_err++; $display("FAIL fwd_running: got %b expected 1", r_h[0]); end
      n_cmp++;
      if ({a_h[3], a_h[4]} !== 2'b01) begin
         n_err++; $display("FAIL fwd_a_first_rise: got %b expected 01", {a_h[3], a_h[4]});
      end
      n_cmp++;
      if ({b_h[7], b_h[8]} !== 2'b01) begin
         n_err++; $display("FAIL fwd_b_rise: got %b expected 01", {b_h[7], b_h[8]});
      end
      n_cmp++;
      if ({a_h[11], a_h[12], a_h[19], a_h[20]} !== 4'b1001) begin
         n_err++; $display("FAIL fwd_a_period: got %b expected 1001", {a_h[11], a_h[12], a_h[19], a_h[20]});
      end
      n_cmp++;
      if (p_h[31] !== 32'd7 || p_h[32] !== 32'd8) begin
         n_err++; $display("FAIL fwd_pos: got %0h/%0h expected 7/8", p_h[31], p_h[32]);
      end
   endtask

   task automatic test_reverse();
      apply_reset();
      gen_enable = 1'b1; direction = 1'b0; phase_period = 16'd4;
      capture(36);
      n_cmp++;
      if ({a_h[4], b_h[3], b_h[4]} !== 3'b001) begin
         n_err++; $display("FAIL rev_b_first: got %b expected 001", {a_h[4], b_h[3], b_h[4]});
      end
      n_cmp++;
      if ({a_h[7], a_h[8]} !== 2'b01) begin
         n_err++; $display("FAIL rev_a_lag: got %b expected 01", {a_h[7], a_h[8]});
      end
      n_cmp++;
      if (p_h[32] !== 32'hFFFF_FFF8) begin
         n_err++; $display("FAIL rev_pos: got %0h expected fffffff8", p_h[32]);
      end
   endtask

   task automatic test_period_one();
      apply_reset();
      gen_enable = 1'b1; direction = 1'b1; phase_period = 16'd1;
      capture(12);
      n_cmp++;
      if ({a_h[1], a_h[2], a_h[5], a_h[6], a_h[9], a_h[10]} !== 6'b011001) begin
         n_err++; $display("FAIL p1_a_period: got %b expected 011001",
                           {a_h[1], a_h[2], a_h[5], a_h[6], a_h[9], a_h[10]});
      end
   endtask

   task automatic test_stop();
      apply_reset();
      gen_enable = 1'b1; direction = 1'b1; phase_period = 16'd4;
      capture(10);
      n_cmp++;
      if (r_h[9] !== 1'b1) begin n_err++; $display("FAIL stop_pre_running: got %b expected 1", r_h[9]); end
      phase_period = 16'd0;
      @(negedge clk);
      n_cmp++;
      if (running !== 1'b0) begin n_err++; $display("FAIL stop_running: got %b expected 0", running); end
      repeat (8) @(negedge clk);
      n_cmp++;
      if ({QE_A, QE_B, running} !== 3'b110 || gen_position !== 32'd2) begin
         n_err++; $display("FAIL stop_hold: got ab_run=%b pos=%0h expected 110 pos=2",
                           {QE_A, QE_B, running}, gen_position);
      end
   endtask

   task automatic test_index();
      int hi_cnt;
      int bad_cnt;
      apply_reset();
      gen_enable = 1'b1; direction = 1'b1; phase_period = 16'd2;
      capture(70);
      hi_cnt = 0; bad_cnt = 0;
      for (int k = 0; k < 70; k++) begin
         if (i_h[k] === 1'b1) begin
            hi_cnt++;
            if ({a_h[k], b_h[k]} !== 2'b00) bad_cnt++;
         end
      end
      n_cmp++;
      if ({i_h[31], i_h[32], i_h[33], i_h[34]} !== 4'b0110) begin
         n_err++; $display("FAIL idx_first: got %b expected 0110", {i_h[31], i_h[32], i_h[33], i_h[34]});
      end
      n_cmp++;
      if ({i_h[63], i_h[64], i_h[65], i_h[66]} !== 4'b0110) begin
         n_err++; $display("FAIL idx_second: got %b expected 0110", {i_h[63], i_h[64], i_h[65], i_h[66]});
      end
      n_cmp++;
      if (hi_cnt != 4 || bad_cnt != 0) begin
         n_err++; $display("FAIL idx_width: got high=%0d off00=%0d expected 4/0", hi_cnt, bad_cnt);
      end
   endtask

   task automatic test_clear();
      apply_reset();
      gen_enable = 1'b1; direction = 1'b1; phase_period = 16'd2;
      capture(5);
      clear_position = 1'b1;
      @(negedge clk);
      clear_position = 1'b0;
      n_cmp++;
      if ({QE_A, QE_B} !== 2'b11 || gen_position !== 32'd0) begin
         n_err++; $display("FAIL clr_pos: got ab=%b pos=%0h expected 11 pos=0", {QE_A, QE_B}, gen_position);
      end
      capture(30);
      n_cmp++;
      if ({i_h[25], i_h[26], i_h[27], i_h[28]} !== 4'b0110) begin
         n_err++; $display("FAIL clr_idx: got %b expected 0110", {i_h[25], i_h[26], i_h[27], i_h[28]});
      end
      n_cmp++;
      if (p_h[26] !== 32'd14 || {a_h[26], b_h[26]} !== 2'b00) begin
         n_err++; $display("FAIL clr_idx_pos: got pos=%0h ab=%b expected 14 ab=00", p_h[26], {a_h[26], b_h[26]});
      end
   endtask

   task automatic test_reversal_and_reset();
      apply_reset();
      gen_enable = 1'b1; direction = 1'b1; phase_period = 16'd4;
      capture(5);
      direction = 1'b0;
      capture(4);
      n_cmp++;
      if ({a_h[2], b_h[2]} !== 2'b10 || p_h[2] !== 32'd1) begin
         n_err++; $display("FAIL flip_pre: got ab=%b pos=%0h expected 10 pos=1", {a_h[2], b_h[2]}, p_h[2]);
      end
      n_cmp++;
      if ({a_h[3], b_h[3]} !== 2'b00 || p_h[3] !== 32'd0) begin
         n_err++; $display("FAIL flip_step: got ab=%b pos=%0h expected 00 pos=0", {a_h[3], b_h[3]}, p_h[3]);
      end
      capture(6);
      reset = 1'b0; gen_enable = 1'b0;
      #1;
      n_cmp++;
      if ({QE_A, QE_B, QE_I, running} !== 4'b0000 || gen_position !== 32'd0) begin
         n_err++; $display("FAIL async_reset: got %b pos=%0h expected 0000 pos=0",
                           {QE_A, QE_B, QE_I, running}, gen_position);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      capture(10);
      n_cmp++;
      if ({QE_A, QE_B, running} !== 3'b000 || gen_position !== 32'd0) begin
         n_err++; $display("FAIL post_reset_idle: got %b pos=%0h expected 000 pos=0",
                           {QE_A, QE_B, running}, gen_position);
      end
      gen_enable = 1'b1; direction = 1'b1; phase_period = 16'd2;
      capture(4);
      n_cmp++;
      if ({a_h[1], a_h[2]} !== 2'b01) begin
         n_err++; $display("FAIL reenable: got %b expected 01", {a_h[1], a_h[2]});
      end
   endtask

   task automatic test_a_high_width();
      apply_reset();
      gen_enable = 1'b1; direction = 1'b1; phase_period = 16'd10;
      capture(72);
      n_cmp++;
      if ({a_h[9], a_h[10], a_h[29], a_h[30]} !== 4'b0110) begin
         n_err++; $display("FAIL ahigh_1: got %b expected 0110", {a_h[9], a_h[10], a_h[29], a_h[30]});
      end
      n_cmp++;
      if ({a_h[49], a_h[50], a_h[69], a_h[70]} !== 4'b0110) begin
         n_err++; $display("FAIL ahigh_2: got %b expected 0110", {a_h[49], a_h[50], a_h[69], a_h[70]});
      end
   endtask

   // sequence and final report
   initial begin
      test_reset();
      test_forward();
      test_reverse();
      test_period_one();
      test_stop();
      test_index();
      test_clear();
      test_reversal_and_reset();
      test_a_high_width();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
